fp_mul_seq: RTL and testbench

- Sequential IEEE-754 single-precision multiplier; the inverse operation of the team's combinational floating-point divider, for the same ALU.
- Uses the same operand/result/flag conventions as the divider: n1, n2, result, Overflow, Underflow, Exception.
- Iterative shift-add datapath: one mantissa bit per cycle, then a normalize stage. Trades latency for area.
- Valid/ready handshake on both input and output.

---
 rtl/fp_mul_seq.sv | 187 ++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: shift-add significand product
// (one multiplier bit per cycle) followed by a normalize stage; truncating.
module fp_mul_seq #(
    parameter int          BIAS = 127,
    parameter int unsigned MW   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] n1,
    input  logic [31:0] n2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Overflow,
    output logic        Underflow,
    output logic        Exception
);

    localparam int unsigned PW = 2 * MW;
    localparam int unsigned CW = 5;
    localparam int unsigned EW = 10;

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  exc_flag_q, exc_flag_d;
    logic                  exc_q, exc_d;
    logic                  sign_q, sign_d;
    logic [MW-1:0]         a_q, a_d;
    logic [MW-1:0]         b_q, b_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic signed [EW-1:0]  e_q, e_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  fin;
    logic signed [EW-1:0]  fin_e;
    logic [PW-1:0]         fin_p;
    logic [7:0]            eff1, eff2;

    // Denormal operands use an effective exponent of 1.
    assign eff1 = (n1[30:23] == 8'h00) ? 8'd1 : n1[30:23];
    assign eff2 = (n2[30:23] == 8'h00) ? 8'd1 : n2[30:23];

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        exc_flag_d  = exc_flag_q;
        exc_d       = exc_q;
        sign_d      = sign_q;
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        e_d         = e_q;
        cnt_d       = cnt_q;
        fin         = 1'b0;
        fin_e       = e_q;
        fin_p       = prod_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d     = n1[31] ^ n2[31];
                    a_d        = {|n1[30:23], n1[22:0]};
                    b_d        = {|n2[30:23], n2[22:0]};
                    e_d        = EW'(eff1) + EW'(eff2) - EW'(BIAS);
                    prod_d     = '0;
                    cnt_d      = '0;
                    exc_d      = (n1[30:23] == 8'hFF) || (n2[30:23] == 8'hFF);
                    in_ready_d = 1'b0;
                    state_d    = MULT;
                end
            end
            MULT: begin
                if (b_q[0]) begin
                    prod_d = prod_q + (PW'(a_q) << cnt_q);
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MW - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if ((prod_q == '0) && !exc_q) begin
                    result_d    = {sign_q, 31'h0};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (prod_q[PW-1]) begin
                    fin_p = prod_q >> 1;
                    fin_e = e_q + EW'(1);
                    fin   = 1'b1;
                end else if (!prod_q[PW-2] && (e_q > 10'sd1)) begin
                    prod_d = prod_q << 1;
                    e_d    = e_q - EW'(1);
                end else begin
                    fin = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    exc_flag_d  = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result packing, flags in priority order so they stay exclusive.
        if (fin) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            e_d         = fin_e;
            prod_d      = fin_p;
            if (exc_q) begin
                result_d   = 32'h7FC0_0000;
                exc_flag_d = 1'b1;
            end else if (fin_e >= 10'sd255) begin
                result_d = {sign_q, 8'hFF, 23'h0};
                ovf_d    = 1'b1;
            end else if (fin_e <= 10'sd0) begin
                result_d = {sign_q, 31'h0};
                unf_d    = 1'b1;
            end else if (!fin_p[PW-2]) begin
                result_d = {sign_q, 8'h00, fin_p[PW-3 -: 23]};
            end else begin
                result_d = {sign_q, fin_e[7:0], fin_p[PW-3 -: 23]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            exc_flag_q  <= 1'b0;
            exc_q       <= 1'b0;
            sign_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            e_q         <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            exc_flag_q  <= exc_flag_d;
            exc_q       <= exc_d;
            sign_q      <= sign_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Exception = exc_flag_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: expected products queued at issue, checked on out_valid.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] n1, n2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        Overflow, Underflow, Exception;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic        ex;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n1        (n1),
        .n2        (n2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Exception (Exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for the result, compare against the queued expectation.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic ov, input logic un, input logic ex,
                          input int lat, input int hold);
        exp_t e;
        int   edges;
        logic busy_ready;
        logic [31:0] held;
        sb.push_back('{res: res, ov: ov, un: un, ex: ex});
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        n1        = a;
        n2        = b;
        out_ready = (hold == 0);
        edges      = 0;
        busy_ready = 1'b0;
        do begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                in_valid = 1'b0;
                n1 = $urandom;
                n2 = $urandom;
            end
            if (in_ready) busy_ready = 1'b1;
        end while (!out_valid && edges < 200);
        check({tag, "_in_ready_busy"}, 32'(busy_ready), 32'd0);
        check({tag, "_latency"}, 32'(edges), 32'(lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_flags"}, {29'h0, Overflow, Underflow, Exception}, {29'h0, e.ov, e.un, e.ex});
        end
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_result"}, result, held);
            check({tag, "_hold_valid"}, {30'h0, out_valid, in_ready}, 32'h2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_accepted"}, {28'h0, out_valid, Overflow, Underflow, Exception}, 32'h0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int edges;
        logic seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n1        = '0;
        n2        = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_flags", {29'h0, Overflow, Underflow, Exception}, 32'h0);

        run_op("mul_2x3",     32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0, 0, 26, 0);
        run_op("mul_1p5sq",   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 0, 0, 0, 26, 0);
        run_op("mul_sign",    32'hC080_0000, 32'h3F00_0000, 32'hC000_0000, 0, 0, 0, 26, 0);
        run_op("mul_ovf",     32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1, 0, 0, 26, 0);
        run_op("mul_unf",     32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 0, 1, 0, 26, 0);
        run_op("mul_inf",     32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 0, 0, 1, 26, 0);
        run_op("mul_zero",    32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, 0, 26, 0);
        run_op("mul_negzero", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 0, 0, 0, 26, 0);
        run_op("mul_denorm",  32'h0040_0000, 32'h4B00_0000, 32'h0B80_0000, 0, 0, 0, 27, 0);
        run_op("mul_hold",    32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0, 0, 26, 10);

        // Abort mid-multiply: reset on the edge where the MULT counter reads 12.
        @(negedge clk);
        in_valid  = 1'b1;
        n1        = 32'h4000_0000;
        n2        = 32'h4040_0000;
        out_ready = 1'b1;
        edges = 0;
        repeat (13) begin
            @(posedge clk);
            edges++;
            #1;
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", 32'(seen_valid), 32'd0);
        out_ready = 1'b0;

        run_op("mul_2x3_post", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0, 0, 26, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
